// File: rtl/alu_stream_sequencer_pkg.sv
// Shared constants for the ALU stream sequencer: mode encoding,
// FSM state codes and the SIMD vector width.
package alu_stream_sequencer_pkg;

  localparam int VEC_W  = 256;
  localparam int LANE_W = 8;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_OR  = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_A = 3'd1;
  localparam state_t ST_LOAD_B = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_stream_sequencer_beat_ctr.sv
// Beat index counter with a terminal flag on the final beat.
// Module alu_seq_beat_ctr, used by alu_stream_sequencer.
module alu_seq_beat_ctr
  import alu_stream_sequencer_pkg::*;
#(
  parameter int NBEATS = 8,
  localparam int KW = cnt_w(NBEATS)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [KW-1:0] o_k,
  output logic          o_term
);

  logic [KW-1:0] r_k;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_k <= '0;
    end else if (i_inc) begin
      r_k <= r_k + KW'(1);
    end
  end

  assign o_k    = r_k;
  assign o_term = (r_k == KW'(NBEATS - 1));

endmodule

// File: rtl/alu_stream_sequencer.sv
// Loads two 256-bit operands beat by beat, runs one SIMD ALU cycle,
// then streams the result out. Optional op_count under ALU_SEQ_PERF_EN.
module alu_stream_sequencer
  import alu_stream_sequencer_pkg::*;
#(
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic [VEC_W-1:0]  op0_value,
  output logic [VEC_W-1:0]  op1_value,
  output logic [1:0]        alu_mode,
  input  logic [VEC_W-1:0]  alu_out,
  output logic              busy
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]       op_count
`endif
);

  localparam int NBEATS = VEC_W / BEAT_W;
  localparam int KW     = cnt_w(NBEATS);

  state_t             r_state;
  logic [VEC_W-1:0]   r_op0;
  logic [VEC_W-1:0]   r_op1;
  logic [VEC_W-1:0]   r_res;
  logic [1:0]         r_mode;

  logic [KW-1:0]      w_k;
  logic               w_term;
  logic               w_idle;
  logic               w_load;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_clr;
  logic               w_inc;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_load     = (r_state == ST_LOAD_A) ||
                      (r_state == ST_LOAD_B);
  assign w_in_fire  = w_load && in_valid;
  assign w_out_fire = (r_state == ST_DRAIN) && out_ready;

  // Counter restarts at each phase boundary so k always indexes the beat.
  assign w_clr = w_idle || (r_state == ST_EXEC) ||
                 (w_in_fire && w_term) ||
                 (w_out_fire && w_term);
  assign w_inc = w_in_fire || w_out_fire;

  alu_seq_beat_ctr #(
    .NBEATS (NBEATS)
  ) u_ctr (
    .clk    (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_k    (w_k),
    .o_term (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op0   <= '0;
      r_op1   <= '0;
      r_res   <= '0;
      r_mode  <= MODE_ADD;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_mode  <= cmd_mode;
            r_state <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            r_op0[w_k*BEAT_W +: BEAT_W] <= in_data;
            if (w_term) r_state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            r_op1[w_k*BEAT_W +: BEAT_W] <= in_data;
            if (w_term) r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res   <= alu_out;
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_ready && w_term) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_fire && w_term) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign op_count = r_op_count;
`endif

  assign cmd_ready = w_idle;
  assign in_ready  = w_load;
  assign out_valid = (r_state == ST_DRAIN);
  assign out_last  = out_valid && w_term;
  assign out_data  = r_res[w_k*BEAT_W +: BEAT_W];
  assign op0_value = r_op0;
  assign op1_value = r_op1;
  assign alu_mode  = r_mode;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_alu_stream_sequencer.sv
// Self-checking bench for alu_stream_sequencer with a lane-wise ALU
// model and a byte-arithmetic reference. Honours ALU_SEQ_PERF_EN.
module tb_alu_stream_sequencer;

  localparam int BW = 32;
  localparam int N  = 256 / BW;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_mode;
  logic           in_valid;
  logic           in_ready;
  logic [BW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [BW-1:0]  out_data;
  logic           out_last;
  logic [255:0]   op0_value;
  logic [255:0]   op1_value;
  logic [1:0]     alu_mode;
  logic [255:0]   alu_out;
  logic           busy;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]    op_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_stream_sequencer #(.BEAT_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .op0_value (op0_value),
    .op1_value (op1_value),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .busy      (busy)
`ifdef ALU_SEQ_PERF_EN
    ,
    .op_count  (op_count)
`endif
  );

  // External SIMD ALU stand-in: 32 independent 8-bit lanes.
  always_comb begin
    alu_out = '0;
    for (int i = 0; i < 32; i++) begin
      case (alu_mode)
        2'b00: alu_out[8*i +: 8] = op0_value[8*i +: 8] + op1_value[8*i +: 8];
        2'b01: alu_out[8*i +: 8] = op0_value[8*i +: 8] & op1_value[8*i +: 8];
        2'b10: alu_out[8*i +: 8] = op0_value[8*i +: 8] | op1_value[8*i +: 8];
        default: alu_out[8*i +: 8] = op0_value[8*i +: 8] ^ op1_value[8*i +: 8];
      endcase
    end
  end

  function automatic logic [255:0] ref_result(input logic [1:0] m,
                                              input logic [255:0] a,
                                              input logic [255:0] b);
    logic [255:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      if (m == 2'd0)      z = (x + y) % 256;
      else if (m == 2'd1) z = x & y;
      else if (m == 2'd2) z = x | y;
      else                z = x ^ y;
      r[8*i +: 8] = 8'(z);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_count(input string tag);
`ifdef ALU_SEQ_PERF_EN
    total++;
    if (op_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL %s op_count got=%0d exp=%0d", tag, op_count, exp_cnt);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic run_txn(input logic [1:0] mode, input logic [255:0] a,
                         input logic [255:0] b, input bit stall,
                         input bit poke, input int bp_beat,
                         input int bp_len, input string tag);
    logic [255:0] exp;
    logic [BW-1:0] eb;
    int j, idx, cyc, hold;
    bit acc, fire;
    exp = ref_result(mode, a, b);
    cyc = 0;
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s cmd_ready got=%b exp=1", tag, cmd_ready);
    end
    @(negedge clk); cyc++;
    cmd_valid = 1'b0;
    j = 0;
    while (j < 2*N && cyc < 400) begin
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (j < N) ? a[j*BW +: BW] : b[(j-N)*BW +: BW];
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s in_ready beat%0d got=%b exp=1", tag, j, in_ready);
      end
      if (poke && j >= N) begin
        cmd_valid = 1'b1;
        cmd_mode  = ~mode;
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s cmd_ready_loadb got=%b exp=0", tag, cmd_ready);
        end
      end
      acc = in_valid && in_ready;
      @(negedge clk); cyc++;
      if (acc) j++;
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    total++;
    if (j < 2*N) begin
      bad++;
      $display("FAIL %s load_timeout got=%0d exp=%0d", tag, j, 2*N);
    end
    idx = 0;
    hold = 0;
    while (idx < N && cyc < 400) begin
      if (idx == bp_beat && hold < bp_len && out_valid) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid) begin
        eb = exp[idx*BW +: BW];
        total++;
        if (out_data !== eb) begin
          bad++;
          $display("FAIL %s data beat%0d got=%h exp=%h", tag, idx, out_data, eb);
        end
        total++;
        if (out_last !== (idx == N-1)) begin
          bad++;
          $display("FAIL %s last beat%0d got=%b exp=%b", tag, idx,
                   out_last, (idx == N-1));
        end
      end
      fire = out_valid && out_ready;
      @(negedge clk); cyc++;
      if (fire) idx++;
    end
    out_ready = 1'b0;
    total++;
    if (idx < N) begin
      bad++;
      $display("FAIL %s drain_timeout got=%0d exp=%0d", tag, idx, N);
    end
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got=%b%b%b exp=010", tag,
               busy, cmd_ready, out_valid);
    end
    total++;
    if (op0_value !== a || op1_value !== b || alu_mode !== mode) begin
      bad++;
      $display("FAIL %s operands_hold got=%h/%0d exp=%h/%0d", tag,
               op0_value[31:0], alu_mode, a[31:0], mode);
    end
    if (!stall && bp_len == 0) begin
      total++;
      if (cyc != 2*N + 1 + N + 1) begin
        bad++;
        $display("FAIL %s period got=%0d exp=%0d", tag, cyc, 2*N + 1 + N + 1);
      end
    end
    exp_cnt++;
    check_count(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = 2'b00;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", busy, out_valid,
               out_last, in_ready);
    end
    total++;
    if (op0_value !== '0 || op1_value !== '0 || alu_mode !== 2'b00) begin
      bad++;
      $display("FAIL reset_regs got=%h/%h/%0d exp=0", op0_value[31:0],
               op1_value[31:0], alu_mode);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    exp_cnt = 0;
    check_count("reset");
  endtask

  task automatic test_add();
    run_txn(2'b00, {32{8'h01}}, {32{8'hFF}}, 1'b0, 1'b0, 0, 0, "add");
  endtask

  task automatic test_logic();
    run_txn(2'b01, {32{8'hF0}}, {32{8'h3C}}, 1'b0, 1'b0, 0, 0, "and");
    run_txn(2'b10, {32{8'hF0}}, {32{8'h3C}}, 1'b0, 1'b0, 0, 0, "or");
    run_txn(2'b11, {32{8'hF0}}, {32{8'h3C}}, 1'b0, 1'b0, 0, 0, "xor");
  endtask

  task automatic test_backpressure();
    run_txn(2'($urandom_range(0, 3)), rand_vec(), rand_vec(),
            1'b0, 1'b0, 3, 5, "backpressure");
  endtask

  task automatic test_input_stall();
    logic [255:0] a, b;
    a = rand_vec();
    b = rand_vec();
    run_txn(2'b00, a, b, 1'b0, 1'b0, 0, 0, "nostall");
    run_txn(2'b00, a, b, 1'b1, 1'b1, 0, 0, "stall");
  endtask

  task automatic test_reset_mid();
    cmd_mode  = 2'b11;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int j = 0; j < N + 4; j++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_mode !== 2'b00) begin
      bad++;
      $display("FAIL midreset_ctrl got=%b%b/%0d exp=00/0", busy,
               out_valid, alu_mode);
    end
    total++;
    if (op0_value !== '0 || op1_value !== '0) begin
      bad++;
      $display("FAIL midreset_regs got=%h/%h exp=0", op0_value[31:0],
               op1_value[31:0]);
    end
    exp_cnt = 0;
    check_count("midreset");
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet got=%b%b exp=00", out_valid, busy);
    end
    run_txn(2'b01, rand_vec(), rand_vec(), 1'b0, 1'b0, 0, 0, "fresh");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      run_txn(2'($urandom_range(0, 3)), rand_vec(), rand_vec(),
              1'b0, 1'b0, 0, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_backpressure();
    test_input_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_stream_sequencer.md
ALU_STREAM_SEQUENCER -- requirements
Module: alu_stream_sequencer

Interface
REQ-001 Parameter BEAT_W, default 32: stream beat width in bits; SHALL divide 256; NBEATS = 256/BEAT_W (default 8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid/cmd_ready  input/output  1/1  command handshake; cmd_mode  input  2  op select (00 add, 01 and, 10 or, 11 xor).
REQ-005 in_valid/in_ready  input/output  1/1  operand stream handshake; in_data  input  BEAT_W  operand beat.
REQ-006 out_valid/out_ready  output/input  1/1  result stream handshake; out_data  output  BEAT_W  result beat; out_last  output  1  final result beat.
REQ-007 op0_value, op1_value  output  256  registered operands to SIMD ALU; alu_mode  output  2  registered mode.
REQ-008 alu_out  input  256  combinational result from SIMD ALU (32 independent 8-bit lanes).
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, LOAD_A, LOAD_B, EXEC, DRAIN.
REQ-011 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd_mode into alu_mode, clear beat counter, go LOAD_A.
REQ-012 LOAD_A/LOAD_B: in_ready=1; each in_valid&in_ready writes in_data to bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k] of op0_value (LOAD_A) or op1_value (LOAD_B), k = beat counter, then k increments.
REQ-013 Beat NBEATS-1 accepted in LOAD_A -> LOAD_B with k=0; in LOAD_B -> EXEC.
REQ-014 EXEC: exactly one cycle; capture alu_out into result register; go DRAIN with k=0.
REQ-015 DRAIN: out_valid=1, out_data = result bits of beat k, out_last=1 iff k=NBEATS-1; advance k on out_valid&out_ready; after last beat go IDLE.
REQ-016 out_data/out_last SHALL stay stable while out_valid&!out_ready; in_valid low stalls loading with no state change.
REQ-017 cmd_ready, in_ready, out_valid SHALL be 0 outside the states named above; cmd_valid outside IDLE is ignored (not queued).
REQ-018 Command in the cycle after last drain beat accepted (IDLE); minimum command-to-command period = 2*NBEATS + 1 + NBEATS + 1 cycles with no stalls.
REQ-019 op0_value, op1_value, alu_mode SHALL hold their values from EXEC until overwritten by the next command's loading.
REQ-020 Lane arithmetic is done by the ALU; add wraps modulo 256 per lane, no carry between lanes.

Reset
REQ-021 rst high at any clock edge SHALL force IDLE, k=0, op0_value=0, op1_value=0, alu_mode=0, result=0, out_valid=0, out_last=0, in_ready=0, cmd_ready=1 after release, busy=0.
REQ-022 Reset mid-transaction SHALL abandon it; no partial result beat emitted afterwards.

Configuration
REQ-023 Macro ALU_SEQ_PERF_EN: when defined, output op_count (32 bits) counts completed transactions (incremented on last accepted drain beat), wraps at 2^32, reset to 0; when undefined, port and counter absent.

Structure
REQ-024 Shared package SHALL hold the 2-bit mode encoding constants (ADD, AND, OR, XOR), the FSM state typedef, and the 256-bit vector width constant.
REQ-025 Top is self-contained; one optional sub-module alu_seq_beat_ctr (beat counter with terminal flag) is natural; ALU instantiated outside.

Verification
REQ-026 Add: op0 all bytes 0x01, op1 all bytes 0xFF, mode 00 -> every out_data beat 0x00000000, out_last on beat 8.
REQ-027 And/Or/Xor: op0=0xF0 lanes, op1=0x3C lanes -> 0x30, 0xFC, 0xCC lane values respectively.
REQ-028 Backpressure: out_ready low 5 cycles on beat 3 -> out_data unchanged, no beat lost or duplicated.
REQ-029 Input stall: in_valid toggled randomly -> result identical to unstalled run; cmd_valid during LOAD_B ignored.
REQ-030 Reset in LOAD_B after 4 beats -> next cycle busy=0, op regs 0; fresh command completes correctly.
REQ-031 With ALU_SEQ_PERF_EN: 3 transactions -> op_count=3; reset -> 0.
